// File: rtl/ones_expand_pkg.sv
// Shared types for the thermometer-code expander: FSM state encoding and default width.
package ones_pkg;
  localparam int W_DEFAULT = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ones_expand_counter.sv
// Up-counter with synchronous active-low clear (priority) and active-low increment.
module counter #(
  parameter int w = 5
) (
  output logic [w-1:0] q,
  input  logic         clock,
  input  logic         reset_L,
  input  logic         clr_L,
  input  logic         inc_L
);
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)    q <= '0;
    else if (!clr_L) q <= '0;
    else if (!inc_L) q <= q + w'(1);
  end
endmodule

// File: rtl/ones_expand_shift.sv
// Serial-in parallel-out right shifter; serial_in enters at the MSB, clr_L wins over shift_L.
module shift_reg_sipo_right #(
  parameter int w = 30
) (
  output logic [w-1:0] q,
  input  logic         serial_in,
  input  logic         clock,
  input  logic         reset_L,
  input  logic         clr_L,
  input  logic         shift_L
);
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)      q <= '0;
    else if (!clr_L)   q <= '0;
    else if (!shift_L) q <= {serial_in, q[w-1:1]};
  end
endmodule

// File: rtl/ones_expand.sv
// Count-to-thermometer expander: builds a w-bit word with k low ones, one bit per cycle.
// Optional ONES_EXPAND_ERR_EN adds an err output flagging a saturated (d_in > w) request.
module ones_expand
  import ones_pkg::*;
#(
  parameter int w = W_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset_L,
  input  logic                     d_in_ready,
  input  logic [$clog2(w+1)-1:0]   d_in,
  output logic                     d_out_ready,
  output logic [w-1:0]             d_out,
  output logic                     busy
`ifdef ONES_EXPAND_ERR_EN
  ,
  output logic                     err
`endif
);
  // state | meaning
  // IDLE  | waiting for d_in_ready; d_out holds the last result
  // FILL  | shifting in one thermometer bit per cycle, w cycles
  // DONE  | d_out complete, d_out_ready pulses for this cycle

  localparam int CW = $clog2(w+1);
  localparam logic [CW-1:0] K_MAX = CW'(w);
  localparam logic [CW-1:0] LAST  = CW'(w - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] kreg;
  logic [CW-1:0] step;
  logic          clr_L, shift_L, inc_L, load;
  logic          serial_in;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      kreg  <= '0;
    end else begin
      state <= state_nxt;
      if (load) kreg <= (d_in > K_MAX) ? K_MAX : d_in;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_L     = 1'b1;
    shift_L   = 1'b1;
    inc_L     = 1'b1;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (d_in_ready) begin
          load      = 1'b1;
          clr_L     = 1'b0;
          state_nxt = FILL;
        end
      end
      FILL: begin
        shift_L = 1'b0;
        inc_L   = 1'b0;
        if (step == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // First bit shifted in ends up at bit 0 after w shifts, so steps 0..k-1 fill the low k bits.
  assign serial_in   = (step < kreg);
  assign d_out_ready = (state == DONE);
  assign busy        = (state != IDLE);

  counter #(.w(CW)) u_step (
    .q       (step),
    .clock   (clock),
    .reset_L (reset_L),
    .clr_L   (clr_L),
    .inc_L   (inc_L)
  );

  shift_reg_sipo_right #(.w(w)) u_shift (
    .q         (d_out),
    .serial_in (serial_in),
    .clock     (clock),
    .reset_L   (reset_L),
    .clr_L     (clr_L),
    .shift_L   (shift_L)
  );

`ifdef ONES_EXPAND_ERR_EN
  logic sat;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)  sat <= 1'b0;
    else if (load) sat <= (d_in > K_MAX);
  end

  assign err = (state == DONE) & sat;
`endif
endmodule

// File: tb/tb_ones_expand.sv
// Directed bench for ones_expand at w=30: latency, boundaries, busy masking, reset abort, round trip.
module tb_ones_expand;
  localparam int W  = 30;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset_L = 1'b0;
  logic          d_in_ready = 1'b0;
  logic [CW-1:0] d_in = '0;
  logic          d_out_ready;
  logic [W-1:0]  d_out;
  logic          busy;
  logic          err_obs;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ones_expand #(.w(W)) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .d_in_ready  (d_in_ready),
    .d_in        (d_in),
    .d_out_ready (d_out_ready),
    .d_out       (d_out),
    .busy        (busy)
`ifdef ONES_EXPAND_ERR_EN
    ,
    .err         (err_obs)
`endif
  );

`ifndef ONES_EXPAND_ERR_EN
  assign err_obs = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues a start and follows it through cycle W+2.
  task automatic run(input logic [CW-1:0] k, input logic [W-1:0] exp, input int exp_err,
                     input int inj_c, input logic [CW-1:0] inj_k, input string tag);
    int rdy_first, rdy_n, busy_n, err_n, err_done;
    logic [W-1:0] got;
    rdy_first = -1; rdy_n = 0; busy_n = 0; err_n = 0; err_done = 0; got = '0;
    d_in = k;
    d_in_ready = 1'b1;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (d_out_ready) begin
        rdy_n++;
        if (rdy_first < 0) rdy_first = c;
      end
      if (err_obs) err_n++;
      if (c == W + 1) begin
        got = d_out;
        err_done = int'(err_obs);
      end
      if (c == W + 2) chk({tag, "_held"}, d_out, exp);
      d_in_ready = (c == inj_c);
      d_in = (c == inj_c) ? inj_k : k;
    end
    chk({tag, "_rdy_cycle"}, rdy_first, W + 1);
    chk({tag, "_rdy_count"}, rdy_n, 1);
    chk({tag, "_busy_cycles"}, busy_n, W + 1);
    chk({tag, "_d_out"}, got, exp);
`ifdef ONES_EXPAND_ERR_EN
    chk({tag, "_err_cycles"}, err_n, exp_err);
    chk({tag, "_err_done"}, err_done, exp_err);
`endif
  endtask

  initial begin
    logic [W-1:0] exp_t;
    int rdy_n;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rdy", d_out_ready, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_err", err_obs, 0);
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);

    run(5'd5,  30'h0000_001F, 0, 0, 5'd0, "k5");
    run(5'd0,  30'h0000_0000, 0, 0, 5'd0, "k0");
    run(5'd30, 30'h3FFF_FFFF, 0, 0, 5'd0, "k30");
    run(5'd31, 30'h3FFF_FFFF, 1, 0, 5'd0, "k31_sat");
    run(5'd3,  30'h0000_0007, 0, 0, 5'd0, "k3");
    // Request during FILL is ignored; the next run starts in cycle W+2 of this one.
    run(5'd7,  30'h0000_007F, 0, 10, 5'd2, "k7_busy_ign");
    run(5'd9,  30'h0000_01FF, 0, 0, 5'd0, "k9_b2b");

    d_in = 5'd20;
    d_in_ready = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clock);
      d_in_ready = 1'b0;
    end
    chk("abort_busy_before", busy, 1);
    reset_L = 1'b0;
    #1;
    chk("abort_d_out", d_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdy", d_out_ready, 0);
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    rdy_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (d_out_ready || busy) rdy_n++;
    end
    chk("abort_no_pulse", rdy_n, 0);
    run(5'd12, 30'h0000_0FFF, 0, 0, 5'd0, "k12_after_abort");

    for (int k = 0; k <= W; k++) begin
      exp_t = (k == 0) ? '0 : ({W{1'b1}} >> (W - k));
      run(CW'(k), exp_t, 0, 0, 5'd0, "loop");
      chk("loop_recount", $countones(d_out), k);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
